// File: rtl/cla16_ripple.sv
// 16-bit registered adder: four 4-bit carry-lookahead slices, with carries rippling only between slices.
// The result is registered with 1-cycle latency and an asynchronous active-low clear.
module cla16_ripple (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C0,
    output logic [15:0] Sum,
    output logic        Cout
);

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned NS = W / SW;

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W:0]    c;
    logic [SW-1:0] gs;
    logic [SW-1:0] ps;
    logic          cy;
    logic [W-1:0]  sum_d;

    assign g = A & B;
    assign p = A ^ B;

    // Carries within a slice are two-level lookahead from the slice carry-in; only c4 ripples onward.
    always_comb begin
        c  = '0;
        gs = '0;
        ps = '0;
        cy = C0;
        for (int k = 0; k < int'(NS); k++) begin
            gs = g[k*SW +: SW];
            ps = p[k*SW +: SW];
            c[k*SW]     = cy;
            c[k*SW + 1] = gs[0] | (ps[0] & cy);
            c[k*SW + 2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cy);
            c[k*SW + 3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                        | (ps[2] & ps[1] & ps[0] & cy);
            cy          = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                        | (ps[3] & ps[2] & ps[1] & gs[0])
                        | (ps[3] & ps[2] & ps[1] & ps[0] & cy);
        end
        c[W] = cy;
    end

    assign sum_d = p ^ c[W-1:0];

    // Output register; reset clears immediately and drops any result in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_d;
            Cout <= c[W];
        end
    end

endmodule

// File: tb/tb_cla16_ripple.sv
// Directed and random checks of cla16_ripple against a queue of expected {Cout,Sum} results.
module tb_cla16_ripple;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        C0;
    logic [15:0] Sum;
    logic        Cout;

    int unsigned n_assert;
    int unsigned n_fail;
    logic [16:0] exp_q[$];

    cla16_ripple dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C0    (C0),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one vector at the falling edge, then compare the popped expectation after the next rising edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [16:0] exp, input string tag);
        logic [16:0] e;
        @(negedge clk);
        A  = a;
        B  = b;
        C0 = ci;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed %h expected none queued", tag, {Cout, Sum});
        end else begin
            e = exp_q.pop_front();
            chk(tag, {Cout, Sum}, e);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        return 17'({1'b0, a}) + 17'({1'b0, b}) + 17'(ci);
    endfunction

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b1;
        A  = 16'hFFFF;
        B  = 16'hFFFF;
        C0 = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reset_async", {Cout, Sum}, 17'h0_0000);

        // Clock keeps toggling under reset with all-ones inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("reset_hold", {Cout, Sum}, 17'h0_0000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        apply(16'hA3AC, 16'h35CC, 1'b0, 17'h0_D978, "s2_first_after_reset");
        apply(16'hE9E4, 16'h8000, 1'b0, 17'h1_69E4, "s3_overflow");
        apply(16'hAF8C, 16'h39F8, 1'b0, 17'h0_E984, "s3_no_overflow");
        apply(16'h0000, 16'hFFFF, 1'b1, 17'h1_0000, "s4_full_chain");
        apply(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, "s4_all_ones");
        apply(16'hE949, 16'h99CC, 1'b1, 17'h1_8316, "s5_vector");
        apply(16'h0001, 16'h0001, 1'b0, 17'h0_0002, "s5_b2b_0");
        apply(16'h00FF, 16'h0001, 1'b0, 17'h0_0100, "s5_b2b_1");
        apply(16'h0FFF, 16'h0000, 1'b1, 17'h0_1000, "s5_b2b_2");
        apply(16'h8000, 16'h8000, 1'b0, 17'h1_0000, "s5_b2b_3");
        apply(16'h0000, 16'h0000, 1'b0, 17'h0_0000, "s5_b2b_zero");
        apply(16'h1234, 16'h4321, 1'b1, 17'h0_5556, "s6_nonzero");

        // Mid-cycle reset with a vector already presented: outputs clear before the edge.
        @(negedge clk);
        A  = 16'hFFFF;
        B  = 16'h0001;
        C0 = 1'b0;
        exp_q.push_back(17'h1_0000);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_clear", {Cout, Sum}, 17'h0_0000);
        exp_q.delete();
        @(posedge clk);
        #1 chk("s6_inflight_dropped", {Cout, Sum}, 17'h0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'h7FFF, 16'h0001, 1'b0, 17'h0_8000, "s6_first_after_release");

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            apply(ra, rb, rc, model(ra, rb, rc), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cla16_ripple.md
CLA16_RIPPLE -- requirements
Module: cla16_ripple

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 A  input  16  addend A, unsigned.
REQ-006 B  input  16  addend B, unsigned.
REQ-007 C0  input  1  carry-in to bit 0.
REQ-008 Sum  output  16  registered sum bits [15:0].
REQ-009 Cout  output  1  registered carry-out of bit 15.

Function
REQ-010 Per-bit generate and propagate SHALL be g[i]=A[i]&B[i] and p[i]=A[i]^B[i].
REQ-011 The combinational core SHALL consist of four 4-bit carry-lookahead slices: slice k covers bits [4k+3:4k].
REQ-012 Inside each slice, carries c1..c4 SHALL be computed with two-level lookahead equations from the slice carry-in, g and p, e.g. c2=g1|p1g0|p1p0cin. They SHALL NOT be computed by bit-to-bit ripple.
REQ-013 Slice carry-out c4 SHALL drive the carry-in of the next slice (ripple between slices only).
REQ-014 Slice 0 carry-in SHALL be C0.
REQ-015 Slice 3 carry-out SHALL be the next-state value of Cout.
REQ-016 The next-state value of Sum[i] SHALL be p[i]^c[i], where c[i] is the carry into bit i.
REQ-017 {Cout,Sum} SHALL equal A+B+C0 exactly (17-bit result) for all 2^33 input combinations.
REQ-018 Overflow SHALL appear only as Cout=1, with no saturation.
REQ-019 Sum and Cout SHALL be registered on the rising edge of clk.
REQ-020 Latency SHALL be 1 cycle: outputs after edge N reflect A, B and C0 sampled at edge N.
REQ-021 A new operand set SHALL be accepted every cycle (throughput 1/cycle).
REQ-022 There SHALL be no handshake, enable or valid signal.
REQ-023 The inputs SHALL NOT be registered; they must be stable around the sampling edge.
REQ-024 The combinational path from A, B, C0 to the register D inputs SHALL contain no latches or loops.
REQ-025 Boundary: 0x0000+0xFFFF+1 SHALL propagate a carry through all 16 bits and all four slices within one cycle.

Reset
REQ-026 While rst_n=0, Sum SHALL be 16'h0000 and Cout SHALL be 0, immediately and independent of clk.
REQ-027 On deassertion of rst_n, the first rising edge SHALL load the result of the current inputs.
REQ-028 Assertion of rst_n between edges SHALL override any pending result.
REQ-029 The result in flight at reset SHALL be discarded, not output later.

Verification
REQ-030 Scenario 1: hold rst_n=0 with A=0xFFFF, B=0xFFFF, C0=1 and toggle clk -> Sum=0x0000, Cout=0 throughout.
REQ-031 Scenario 2: A=0xA3AC, B=0x35CC, C0=0, one edge -> Sum=0xD978, Cout=0.
REQ-032 Scenario 3: A=0xE9E4, B=0x8000, C0=0 -> Sum=0x69E4, Cout=1; and A=0xAF8C, B=0x39F8, C0=0 -> Sum=0xE984, Cout=0.
REQ-033 Scenario 4: A=0x0000, B=0xFFFF, C0=1 -> Sum=0x0000, Cout=1 (full-chain ripple); and A=0xFFFF, B=0xFFFF, C0=1 -> Sum=0xFFFF, Cout=1.
REQ-034 Scenario 5: A=0xE949, B=0x99CC, C0=1 -> Sum=0x8316, Cout=1.
REQ-035 Scenario 5 back-to-back: apply a new vector each cycle -> each result appears exactly one edge later, with no bubbles.
REQ-036 Scenario 6: drop rst_n asynchronously mid-cycle after a nonzero result -> outputs go to zero before the next edge.
REQ-037 Scenario 6 self-check: drive 10,000 random vectors and compare {Cout,Sum} against A+B+C0 with one-cycle delay.
